// File: rtl/nmcu_dispatcher_if.sv
// NMCU launch handshake bundle: the dispatcher drives the start pulse and the window
// addresses, and the NMCU array returns per-unit read_complete and done levels.
interface nmcu_dispatcher_if #(
  parameter int unsigned ADDR_WIDTH = 16,
  parameter int unsigned NUM_NMCUS  = 9
) ();

  logic [NUM_NMCUS-1:0]  start;
  logic [NUM_NMCUS-1:0]  read_complete;
  logic [NUM_NMCUS-1:0]  done;
  logic [ADDR_WIDTH-1:0] input_addr;
  logic [ADDR_WIDTH-1:0] output_addr;

  // Dispatcher side.
  modport master (
    output start,
    output input_addr,
    output output_addr,
    input  read_complete,
    input  done
  );

  // NMCU array side.
  modport slave (
    input  start,
    input  input_addr,
    input  output_addr,
    output read_complete,
    output done
  );

endinterface

// File: rtl/nmcu_dispatcher.sv
// NMCU dispatcher: walks the output grid in row-major order and launches one NMCU per
// output pixel. The read phases are serialised on read_complete, all units are then
// awaited on done, and the whole run is reported with a one-cycle all_done pulse.
// A watchdog bounds every wait state and aborts the run with a one-cycle error pulse.
module nmcu_dispatcher #(
  parameter int unsigned ADDR_WIDTH    = 16,
  parameter int unsigned MAX_INPUT_DIM = 15,
  parameter int unsigned NUM_NMCUS     = 9,
  parameter int unsigned TIMEOUT       = 4096,
  localparam int unsigned DW           = $clog2(MAX_INPUT_DIM) + 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  go,
  input  logic [ADDR_WIDTH-1:0] in_base,
  input  logic [ADDR_WIDTH-1:0] out_base,
  input  logic [DW-1:0]         full_input_width,
  input  logic [DW-1:0]         full_output_width,
  input  logic [DW-1:0]         full_output_height,
  output logic                  busy,
  output logic                  all_done,
  output logic                  error,
  nmcu_dispatcher_if.master     nmcu
);

  localparam int unsigned IdxW = (NUM_NMCUS > 1) ? $clog2(NUM_NMCUS) : 1;
  localparam int unsigned WdW  = $clog2(TIMEOUT) + 1;
  localparam int unsigned NW   = 2 * DW;

  typedef enum logic [2:0] {
    StIdle,
    StIssue,
    StWaitRc,
    StGap,
    StWaitDone,
    StFinish
  } state_e;

  state_e                state_q, state_d;
  logic [IdxW-1:0]       idx_q, idx_d;
  logic [IdxW-1:0]       last_q, last_d;
  logic [DW-1:0]         col_q, col_d;
  logic [DW-1:0]         in_pitch_q, in_pitch_d;
  logic [DW-1:0]         out_w_q, out_w_d;
  logic [ADDR_WIDTH-1:0] in_row_q, in_row_d;
  logic [ADDR_WIDTH-1:0] out_row_q, out_row_d;
  logic [ADDR_WIDTH-1:0] in_addr_q, in_addr_d;
  logic [ADDR_WIDTH-1:0] out_addr_q, out_addr_d;
  logic [WdW-1:0]        wdog_q, wdog_d;
  logic                  error_q, error_d;

  logic [NW-1:0]         n_prod;
  logic                  go_valid;
  logic [NUM_NMCUS-1:0]  sel;
  logic [NUM_NMCUS-1:0]  mask;
  logic                  rc_hit;
  logic                  done_hit;
  logic                  wdog_expired;
  logic                  last_col;

  // Grid size check for an incoming go; only a tiny DW x DW product.
  always_comb begin
    n_prod   = NW'(full_output_width) * NW'(full_output_height);
    go_valid = (n_prod != '0) && (n_prod <= NW'(NUM_NMCUS));
  end

  // One-hot select of the current NMCU and the mask of all launched NMCUs.
  always_comb begin
    sel  = '0;
    mask = '0;
    for (int i = 0; i < NUM_NMCUS; i++) begin
      sel[i]  = (idx_q == IdxW'(i));
      mask[i] = (IdxW'(i) <= last_q);
    end
  end

  // Handshake qualifiers; read_complete of other units and done beyond N are ignored.
  always_comb begin
    rc_hit       = |(nmcu.read_complete & sel);
    done_hit     = ((nmcu.done & mask) == mask);
    wdog_expired = (wdog_q == WdW'(TIMEOUT - 1));
    last_col     = (col_q == out_w_q - DW'(1));
  end

  // Next-state logic: sequencing, incremental address walk and watchdog.
  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    last_d     = last_q;
    col_d      = col_q;
    in_pitch_d = in_pitch_q;
    out_w_d    = out_w_q;
    in_row_d   = in_row_q;
    out_row_d  = out_row_q;
    in_addr_d  = in_addr_q;
    out_addr_d = out_addr_q;
    wdog_d     = wdog_q;
    error_d    = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (go) begin
          if (go_valid) begin
            state_d    = StIssue;
            idx_d      = '0;
            col_d      = '0;
            last_d     = IdxW'(n_prod - NW'(1));
            in_pitch_d = full_input_width;
            out_w_d    = full_output_width;
            in_row_d   = in_base;
            out_row_d  = out_base;
            in_addr_d  = in_base;
            out_addr_d = out_base;
          end else begin
            error_d = 1'b1;
          end
        end
      end

      StIssue: begin
        state_d = StWaitRc;
        wdog_d  = '0;
      end

      StWaitRc: begin
        if (rc_hit) begin
          if (idx_q == last_q) begin
            state_d = StWaitDone;
            wdog_d  = '0;
          end else begin
            state_d = StGap;
            idx_d   = idx_q + IdxW'(1);
            if (last_col) begin
              // Wrap to the next row: both row bases step by their own pitch.
              col_d     = '0;
              in_row_d  = in_row_q + ADDR_WIDTH'(in_pitch_q);
              out_row_d = out_row_q + ADDR_WIDTH'(out_w_q);
            end else begin
              col_d = col_q + DW'(1);
            end
          end
        end else if (wdog_expired) begin
          state_d = StIdle;
          error_d = 1'b1;
        end else begin
          wdog_d = wdog_q + WdW'(1);
        end
      end

      StGap: begin
        // Addresses change only here so they stay stable from one ISSUE to the next.
        state_d    = StIssue;
        in_addr_d  = in_row_q + ADDR_WIDTH'(col_q);
        out_addr_d = out_row_q + ADDR_WIDTH'(col_q);
      end

      StWaitDone: begin
        if (done_hit) begin
          state_d = StFinish;
        end else if (wdog_expired) begin
          state_d = StIdle;
          error_d = 1'b1;
        end else begin
          wdog_d = wdog_q + WdW'(1);
        end
      end

      StFinish: begin
        state_d = StIdle;
      end

      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StIdle;
      idx_q      <= '0;
      last_q     <= '0;
      col_q      <= '0;
      in_pitch_q <= '0;
      out_w_q    <= '0;
      in_row_q   <= '0;
      out_row_q  <= '0;
      in_addr_q  <= '0;
      out_addr_q <= '0;
      wdog_q     <= '0;
      error_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      last_q     <= last_d;
      col_q      <= col_d;
      in_pitch_q <= in_pitch_d;
      out_w_q    <= out_w_d;
      in_row_q   <= in_row_d;
      out_row_q  <= out_row_d;
      in_addr_q  <= in_addr_d;
      out_addr_q <= out_addr_d;
      wdog_q     <= wdog_d;
      error_q    <= error_d;
    end
  end

  // Output decode from registered state.
  always_comb begin
    nmcu.start       = (state_q == StIssue) ? sel : '0;
    nmcu.input_addr  = in_addr_q;
    nmcu.output_addr = out_addr_q;
    busy             = (state_q == StIssue) || (state_q == StWaitRc) ||
                       (state_q == StGap)   || (state_q == StWaitDone);
    all_done         = (state_q == StFinish);
    error            = error_q;
  end

endmodule

// File: tb/tb_nmcu_dispatcher.sv
// Bench for nmcu_dispatcher: a behavioural NMCU array responds to start pulses, a monitor
// logs every launch, and each run is compared with addresses computed directly from the
// row-major grid formula.
module tb_nmcu_dispatcher;

  localparam int unsigned AW  = 16;
  localparam int unsigned MID = 15;
  localparam int unsigned NN  = 9;
  localparam int unsigned TO  = 4096;
  localparam int unsigned DW  = $clog2(MID) + 1;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          go = 1'b0;
  logic [AW-1:0] in_base = '0;
  logic [AW-1:0] out_base = '0;
  logic [DW-1:0] fiw = '0;
  logic [DW-1:0] fow = '0;
  logic [DW-1:0] foh = '0;
  logic          busy, all_done, error;

  nmcu_dispatcher_if #(.ADDR_WIDTH(AW), .NUM_NMCUS(NN)) nmcu ();

  nmcu_dispatcher #(
    .ADDR_WIDTH(AW), .MAX_INPUT_DIM(MID), .NUM_NMCUS(NN), .TIMEOUT(TO)
  ) dut (
    .clk(clk), .rst(rst), .go(go), .in_base(in_base), .out_base(out_base),
    .full_input_width(fiw), .full_output_width(fow), .full_output_height(foh),
    .busy(busy), .all_done(all_done), .error(error), .nmcu(nmcu)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Responder: read_complete rc_delay cycles after start, done done_delay cycles later.
  logic [NN-1:0] resp_rc = '0, resp_done = '0, rc_block = '0, rc_force = '0;
  logic          resp_clr = 1'b0, mon_clr = 1'b0;
  int            rc_delay = 5, done_delay = 20;
  int            rc_tmr[NN], dn_tmr[NN], rc_cyc[NN], dn_cyc[NN];

  assign nmcu.read_complete = (resp_rc & ~rc_block) | rc_force;
  assign nmcu.done          = resp_done;

  always @(negedge clk) begin
    for (int i = 0; i < NN; i++) begin
      if (resp_clr) begin
        rc_tmr[i] <= 0; dn_tmr[i] <= 0; resp_rc[i] <= 1'b0; resp_done[i] <= 1'b0;
      end else if (nmcu.start[i]) begin
        resp_rc[i] <= 1'b0; resp_done[i] <= 1'b0; rc_tmr[i] <= rc_delay; dn_tmr[i] <= 0;
      end else if (rc_tmr[i] == 1) begin
        rc_tmr[i] <= 0; resp_rc[i] <= 1'b1; rc_cyc[i] <= cyc; dn_tmr[i] <= done_delay;
      end else if (rc_tmr[i] > 1) begin
        rc_tmr[i] <= rc_tmr[i] - 1;
      end else if (dn_tmr[i] == 1) begin
        dn_tmr[i] <= 0; resp_done[i] <= 1'b1; dn_cyc[i] <= cyc;
      end else if (dn_tmr[i] > 1) begin
        dn_tmr[i] <= dn_tmr[i] - 1;
      end
    end
  end

  // Monitor: log start pulses, all_done and error pulses with their cycle numbers.
  typedef struct {
    int            cyc;
    logic [NN-1:0] st;
    logic [AW-1:0] ia;
    logic [AW-1:0] oa;
    logic          bsy;
  } ev_t;

  ev_t st_q[$];
  int  ad_q[$];
  int  er_q[$];

  always @(negedge clk) begin
    if (mon_clr) begin
      st_q.delete(); ad_q.delete(); er_q.delete();
    end else begin
      if (nmcu.start != '0)
        st_q.push_back(ev_t'{cyc, nmcu.start, nmcu.input_addr, nmcu.output_addr, busy});
      if (all_done) ad_q.push_back(cyc);
      if (error) er_q.push_back(cyc);
    end
  end

  int n_checks = 0;
  int n_fail = 0;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic configure(input logic [AW-1:0] ib, input logic [AW-1:0] ob,
                           input int iw, input int w, input int h);
    resp_clr = 1'b1; mon_clr = 1'b1;
    tick(1);
    resp_clr = 1'b0; mon_clr = 1'b0;
    in_base = ib; out_base = ob;
    fiw = DW'(iw); fow = DW'(w); foh = DW'(h);
  endtask

  task automatic pulse_go(output int gcyc);
    go = 1'b1;
    gcyc = cyc;
    tick(1);
    go = 1'b0;
  endtask

  // Waits for all_done or error; optionally injects a second go mid-run with new inputs.
  task automatic wait_end(input int bound, input int extra, output bit ok);
    ok = 1'b0;
    for (int j = 0; j < bound; j++) begin
      if (all_done || error) begin
        ok = 1'b1;
        break;
      end
      if (j == extra) begin
        go = 1'b1; in_base = in_base ^ 16'h5555; out_base = ~out_base; fiw = fiw + DW'(1);
      end else begin
        go = 1'b0;
      end
      tick(1);
    end
    go = 1'b0;
  endtask

  // Full run compared with the row-major reference: r = k / w, c = k % w.
  task automatic run_grid(input string tag, input logic [AW-1:0] ib, input logic [AW-1:0] ob,
                          input int iw, input int w, input int h, input int extra);
    int            g, n, r, c, maxdn;
    bit            ok;
    logic [AW-1:0] exp_ia, exp_oa;
    configure(ib, ob, iw, w, h);
    pulse_go(g);
    wait_end(3000, extra, ok);
    check({tag, " run_ends"}, ok, 1);
    check({tag, " ends_by_all_done"}, all_done, 1);
    check({tag, " busy_low_at_finish"}, busy, 0);
    tick(3);
    n = w * h;
    check({tag, " start_count"}, st_q.size(), n);
    maxdn = 0;
    for (int k = 0; k < n && k < st_q.size(); k++) begin
      r = k / w;
      c = k % w;
      exp_ia = AW'(int'(ib) + r * iw + c);
      exp_oa = AW'(int'(ob) + r * w + c);
      check($sformatf("%s start_onehot[%0d]", tag, k), st_q[k].st, NN'(1) << k);
      check($sformatf("%s input_addr[%0d]", tag, k), st_q[k].ia, exp_ia);
      check($sformatf("%s output_addr[%0d]", tag, k), st_q[k].oa, exp_oa);
      check($sformatf("%s busy_at_start[%0d]", tag, k), st_q[k].bsy, 1);
      if (k == 0) check({tag, " go_to_start0"}, st_q[k].cyc, g + 1);
      else check($sformatf("%s rc_to_start[%0d]", tag, k), st_q[k].cyc, rc_cyc[k-1] + 2);
      if (dn_cyc[k] > maxdn) maxdn = dn_cyc[k];
    end
    check({tag, " all_done_count"}, ad_q.size(), 1);
    if (ad_q.size() > 0) check({tag, " all_done_cycle"}, ad_q[0], maxdn + 1);
    check({tag, " error_count"}, er_q.size(), 0);
  endtask

  typedef struct {
    logic [DW-1:0] w;
    logic [DW-1:0] h;
    logic          exp_err;
    logic          exp_busy;
    logic [NN-1:0] exp_start;
  } vec_t;

  function automatic vec_t mk(input int w, input int h, input bit e, input bit b,
                              input int st);
    vec_t v;
    v.w = DW'(w); v.h = DW'(h); v.exp_err = e; v.exp_busy = b; v.exp_start = NN'(st);
    return v;
  endfunction

  initial begin
    vec_t          tbl[8];
    int            g, s1, e1, w, h;
    bit            ok, found;
    logic [AW-1:0] ib;

    tbl[0] = mk(4, 3, 1, 0, 0);
    tbl[1] = mk(0, 3, 1, 0, 0);
    tbl[2] = mk(3, 0, 1, 0, 0);
    tbl[3] = mk(10, 1, 1, 0, 0);
    tbl[4] = mk(1, 1, 0, 1, 1);
    tbl[5] = mk(9, 1, 0, 1, 1);
    tbl[6] = mk(2, 4, 0, 1, 1);
    tbl[7] = mk(15, 15, 1, 0, 0);

    // Reset values.
    tick(3);
    check("rst start", nmcu.start, 0);
    check("rst input_addr", nmcu.input_addr, 0);
    check("rst output_addr", nmcu.output_addr, 0);
    check("rst busy", busy, 0);
    check("rst all_done", all_done, 0);
    check("rst error", error, 0);
    rst = 1'b0;
    tick(2);

    // go validation table.
    for (int i = 0; i < 8; i++) begin
      configure(16'h0040, 16'h0800, 5, int'(tbl[i].w), int'(tbl[i].h));
      pulse_go(g);
      check($sformatf("tbl[%0d] error", i), error, tbl[i].exp_err);
      check($sformatf("tbl[%0d] busy", i), busy, tbl[i].exp_busy);
      check($sformatf("tbl[%0d] start", i), nmcu.start, tbl[i].exp_start);
      if (tbl[i].exp_busy) begin
        wait_end(3000, -1, ok);
        check($sformatf("tbl[%0d] completes", i), all_done, 1);
      end else begin
        tick(2);
        check($sformatf("tbl[%0d] error_one_cycle", i), error, 0);
        check($sformatf("tbl[%0d] stays_idle", i), busy, 0);
        check($sformatf("tbl[%0d] no_start", i), st_q.size(), 0);
      end
      tick(2);
    end

    // Directed runs.
    rc_delay = 5; done_delay = 20;
    run_grid("grid3x3", 16'h0100, 16'h0200, 6, 3, 3, -1);
    run_grid("grid1x1", 16'h0100, 16'h0200, 6, 1, 1, -1);

    // Foreign read_complete does not advance; missing read_complete trips the watchdog.
    rc_block = NN'(1) << 1;
    rc_force = NN'(1) << 5;
    configure(16'h0100, 16'h0200, 6, 3, 3);
    pulse_go(g);
    found = 1'b0; s1 = 0;
    for (int j = 0; j < 200; j++) begin
      if (nmcu.start[1]) begin found = 1'b1; s1 = cyc; break; end
      tick(1);
    end
    check("wdog start1_seen", found, 1);
    tick(40);
    check("wdog no_advance", st_q.size(), 2);
    check("wdog still_busy", busy, 1);
    found = 1'b0; e1 = 0;
    for (int j = 0; j < int'(TO) + 100; j++) begin
      if (error) begin found = 1'b1; e1 = cyc; break; end
      tick(1);
    end
    check("wdog error_seen", found, 1);
    check("wdog error_cycle", e1, s1 + int'(TO) + 1);
    check("wdog busy_dropped", busy, 0);
    tick(1);
    check("wdog error_one_cycle", error, 0);
    tick(5);
    check("wdog no_more_starts", st_q.size(), 2);
    rc_block = '0; rc_force = '0;

    // Reset while waiting on index 4, then a clean restart.
    rc_block = NN'(1) << 4;
    configure(16'h0100, 16'h0200, 6, 3, 3);
    pulse_go(g);
    found = 1'b0;
    for (int j = 0; j < 300; j++) begin
      if (nmcu.start[4]) begin found = 1'b1; break; end
      tick(1);
    end
    check("midrst start4_seen", found, 1);
    tick(3);
    rst = 1'b1;
    tick(1);
    check("midrst start", nmcu.start, 0);
    check("midrst input_addr", nmcu.input_addr, 0);
    check("midrst output_addr", nmcu.output_addr, 0);
    check("midrst busy", busy, 0);
    check("midrst all_done", all_done, 0);
    check("midrst error", error, 0);
    rst = 1'b0;
    tick(10);
    check("midrst no_more_starts", st_q.size(), 5);
    rc_block = '0;
    run_grid("restart", 16'h0100, 16'h0200, 6, 3, 3, -1);

    // A second go mid-run, with changed inputs, must be ignored.
    run_grid("second_go", 16'h0100, 16'h0200, 6, 3, 3, 3);

    // Randomised grids, bases (some near wrap) and responder delays.
    for (int t = 0; t < 10; t++) begin
      w = int'($urandom_range(1, 9));
      h = int'($urandom_range(1, 9 / w));
      ib = AW'($urandom);
      if ($urandom_range(0, 2) == 0) ib = 16'hFFFE;
      rc_delay = int'($urandom_range(1, 6));
      done_delay = int'($urandom_range(1, 30));
      run_grid($sformatf("rand%0d", t), ib, AW'($urandom), int'($urandom_range(0, 15)), w, h,
               -1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
